// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and ID/EX pipeline registers with load-use bubble insertion,
// branch flush and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter logic [31:0] NOP_INS    = 32'h00000013,
  parameter int          BUBBLE_LEN = 1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_ins,
  input  logic [31:0]      if_pc,
  input  logic             if_valid,
  input  logic             load_use_stall,
  input  logic             flush,
  output logic [31:0]      ins0,
  output logic [31:0]      ins0_pc,
  output logic             ins0_valid,
  output logic [31:0]      ins1,
  output logic [31:0]      ins1_pc,
  output logic             ins1_valid,
  output logic             pc_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int REM_W = $clog2(BUBBLE_LEN + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_next;
  logic [REM_W-1:0] rem, rem_next;
  logic             bubble;   // this cycle pushes a NOP into execute
  logic             advance;  // this cycle shifts fetch -> decode -> execute

  // Next-state, remaining-bubble count and pipeline control; flush wins over everything.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    pc_hold    = 1'b0;
    bubble     = 1'b0;
    advance    = 1'b0;
    if (flush) begin
      // Fetch is being redirected, so the PC must not be held.
      state_next = RUN;
      rem_next   = '0;
    end else if (state == STALL) begin
      // Requests are ignored here; the bubble train is already committed.
      pc_hold  = 1'b1;
      bubble   = 1'b1;
      rem_next = rem - REM_W'(1);
      if (rem == REM_W'(1)) begin
        state_next = RUN;
      end
    end else if (load_use_stall) begin
      pc_hold = 1'b1;
      bubble  = 1'b1;
      if (BUBBLE_LEN > 1) begin
        state_next = STALL;
        rem_next   = REM_W'(BUBBLE_LEN - 1);
      end
    end else begin
      advance = 1'b1;
    end
  end

  // State register and bubble down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // IF/ID and ID/EX registers: kill on flush, hold decode on bubble, else shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins0       <= NOP_INS;
      ins0_pc    <= '0;
      ins0_valid <= 1'b0;
      ins1       <= NOP_INS;
      ins1_pc    <= '0;
      ins1_valid <= 1'b0;
    end else if (flush) begin
      ins0       <= NOP_INS;
      ins0_valid <= 1'b0;
      ins1       <= NOP_INS;
      ins1_valid <= 1'b0;
    end else if (bubble) begin
      // The bubble carries the PC of the instruction waiting in decode.
      ins1       <= NOP_INS;
      ins1_pc    <= ins0_pc;
      ins1_valid <= 1'b0;
    end else if (advance) begin
      ins1       <= ins0;
      ins1_pc    <= ins0_pc;
      ins1_valid <= ins0_valid;
      ins0       <= if_valid ? if_ins : NOP_INS;
      ins0_pc    <= if_pc;
      ins0_valid <= if_valid;
    end
  end

  // Saturating event counters: bubbles inserted (not flushed) and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one instance with default parameters, one with
// BUBBLE_LEN=3 and a 4-bit counter to reach saturation quickly.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LW  = 32'h0002A283;
  localparam logic [31:0] ADD = 32'h00128333;
  localparam logic [31:0] ADI = 32'h00A00093;
  localparam logic [31:0] I3  = 32'h00208193;
  localparam logic [31:0] I4  = 32'h00310213;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_ins, if_pc;
  logic        if_valid, load_use_stall, flush;

  logic [31:0] ins0, ins0_pc, ins1, ins1_pc;
  logic        ins0_valid, ins1_valid, pc_hold;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] ins0_b, ins0_pc_b, ins1_b, ins1_pc_b;
  logic        ins0_valid_b, ins1_valid_b, pc_hold_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid),
    .load_use_stall(load_use_stall), .flush(flush),
    .ins0(ins0), .ins0_pc(ins0_pc), .ins0_valid(ins0_valid),
    .ins1(ins1), .ins1_pc(ins1_pc), .ins1_valid(ins1_valid),
    .pc_hold(pc_hold), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.BUBBLE_LEN(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid),
    .load_use_stall(load_use_stall), .flush(flush),
    .ins0(ins0_b), .ins0_pc(ins0_pc_b), .ins0_valid(ins0_valid_b),
    .ins1(ins1_b), .ins1_pc(ins1_pc_b), .ins1_valid(ins1_valid_b),
    .pc_hold(pc_hold_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    if_ins   = ins;
    if_pc    = pc;
    if_valid = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_ins = '0; if_pc = '0; if_valid = 1'b0;
    load_use_stall = 1'b0; flush = 1'b0;
    #2;
    // Reset values
    check_val("rst_ins0",   ins0, NOP);
    check_val("rst_ins1",   ins1, NOP);
    check_val("rst_pc1",    ins1_pc, 32'h0);
    check_val("rst_valids", {30'd0, ins0_valid, ins1_valid}, 32'h0);
    check_val("rst_cnts",   {stall_cnt, flush_cnt}, 32'h0);
    check_val("rst_hold",   {31'd0, pc_hold}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- Load-use with BUBBLE_LEN=1 ----
    fetch(LW, 32'h100, 1'b1);  tick();
    fetch(ADD, 32'h104, 1'b1); tick();
    check_val("lu_ins0_pre", ins0, ADD);
    check_val("lu_ins1_pre", ins1, LW);
    check_val("lu_pc1_pre",  ins1_pc, 32'h100);
    fetch(ADI, 32'h108, 1'b1);
    load_use_stall = 1'b1; #1;
    check_val("lu_hold", {31'd0, pc_hold}, 32'h1);
    tick();
    check_val("lu_bub_ins1",  ins1, NOP);
    check_val("lu_bub_v1",    {31'd0, ins1_valid}, 32'h0);
    check_val("lu_bub_pc1",   ins1_pc, 32'h104);
    check_val("lu_bub_ins0",  ins0, ADD);
    check_val("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    load_use_stall = 1'b0; #1;
    check_val("lu_hold_clr", {31'd0, pc_hold}, 32'h0);
    tick();
    check_val("lu_adv_ins1", ins1, ADD);
    check_val("lu_adv_ins0", ins0, ADI);

    // ---- if_valid=0 inserts a NOP that flows through ----
    fetch(32'hDEADBEEF, 32'h10C, 1'b0); tick();
    check_val("iv_ins0",   ins0, NOP);
    check_val("iv_v0",     {31'd0, ins0_valid}, 32'h0);
    check_val("iv_pc0",    ins0_pc, 32'h10C);
    fetch(I3, 32'h110, 1'b1); tick();
    check_val("iv_ins1",   ins1, NOP);
    check_val("iv_v1",     {31'd0, ins1_valid}, 32'h0);
    check_val("iv_ins0_n", ins0, I3);

    // ---- Flush and stall in the same cycle ----
    flush = 1'b1; load_use_stall = 1'b1; #1;
    check_val("fs_hold", {31'd0, pc_hold}, 32'h0);
    tick();
    flush = 1'b0; load_use_stall = 1'b0;
    check_val("fs_ins0",  ins0, NOP);
    check_val("fs_ins1",  ins1, NOP);
    check_val("fs_valid", {30'd0, ins0_valid, ins1_valid}, 32'h0);
    check_val("fs_fcnt",  {16'd0, flush_cnt}, 32'd1);
    check_val("fs_scnt",  {16'd0, stall_cnt}, 32'd1);

    // ---- BUBBLE_LEN=3: single stall pulse ----
    do_reset();
    fetch(LW, 32'h100, 1'b1);  tick();
    fetch(ADD, 32'h104, 1'b1); tick();
    fetch(ADI, 32'h108, 1'b1);
    load_use_stall = 1'b1; #1;
    check_val("b3_hold_a", {31'd0, pc_hold_b}, 32'h1);
    tick();
    load_use_stall = 1'b0; #1;
    check_val("b3_ins1_a", ins1_b, NOP);
    check_val("b3_ins0_a", ins0_b, ADD);
    check_val("b3_hold_b", {31'd0, pc_hold_b}, 32'h1);
    tick();
    check_val("b3_ins1_b", ins1_b, NOP);
    check_val("b3_ins0_b", ins0_b, ADD);
    check_val("b3_hold_c", {31'd0, pc_hold_b}, 32'h1);
    tick();
    check_val("b3_ins1_c", ins1_b, NOP);
    check_val("b3_v1_c",   {31'd0, ins1_valid_b}, 32'h0);
    check_val("b3_ins0_c", ins0_b, ADD);
    check_val("b3_scnt",   {28'd0, stall_cnt_b}, 32'd3);
    check_val("b3_hold_d", {31'd0, pc_hold_b}, 32'h0);
    tick();
    check_val("b3_ins1_d", ins1_b, ADD);
    check_val("b3_ins0_d", ins0_b, ADI);

    // ---- Flush on the 2nd bubble of a BUBBLE_LEN=3 stall ----
    load_use_stall = 1'b1; tick();
    load_use_stall = 1'b0; flush = 1'b1; #1;
    check_val("fb_hold", {31'd0, pc_hold_b}, 32'h0);
    tick();
    flush = 1'b0;
    fetch(I4, 32'h200, 1'b1); #1;
    check_val("fb_ins0",   ins0_b, NOP);
    check_val("fb_ins1",   ins1_b, NOP);
    check_val("fb_fcnt",   {28'd0, flush_cnt_b}, 32'd1);
    check_val("fb_scnt",   {28'd0, stall_cnt_b}, 32'd4);
    check_val("fb_run",    {31'd0, pc_hold_b}, 32'h0);
    tick();
    check_val("fb_adv",    ins0_b, I4);
    check_val("fb_adv_pc", ins0_pc_b, 32'h200);

    // ---- Async reset in the middle of a STALL ----
    load_use_stall = 1'b1; tick();
    load_use_stall = 1'b0; #1;
    check_val("ar_in_stall", {31'd0, pc_hold_b}, 32'h1);
    rst = 1'b1; #1;
    check_val("ar_ins0",  ins0_b, NOP);
    check_val("ar_ins1",  ins1_b, NOP);
    check_val("ar_pc0",   ins0_pc_b, 32'h0);
    check_val("ar_valid", {30'd0, ins0_valid_b, ins1_valid_b}, 32'h0);
    check_val("ar_cnts",  {24'd0, stall_cnt_b, flush_cnt_b}, 32'h0);
    check_val("ar_hold",  {31'd0, pc_hold_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- Counter saturation (4-bit instance) ----
    load_use_stall = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check_val("sat_14", {28'd0, stall_cnt_b}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check_val("sat_max", {28'd0, stall_cnt_b}, 32'd15);
    load_use_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
